// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared state encoding and default geometry for the multi-bank RAM
package ram_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    // Defaults shared with the solver control unit
    localparam int DEF_DATA_WIDTH    = 64;
    localparam int DEF_NUM_BANKS     = 4;
    localparam int DEF_ADDRESS_WIDTH = 12;

endpackage

// File: rtl/multi_bank_ram_if.sv
// rtl/multi_bank_ram_if.sv - per-bank command/data bus between solver control and the RAM
interface multi_bank_ram_if #(
    parameter int DATA_WIDTH    = 64,
    parameter int NUM_BANKS     = 4,
    parameter int ADDRESS_WIDTH = 12
);

    logic [NUM_BANKS*ADDRESS_WIDTH-1:0] address;
    logic [NUM_BANKS*DATA_WIDTH-1:0]    data_in;
    logic [NUM_BANKS-1:0]               WR_signal;
    logic [NUM_BANKS-1:0]               RD_signal;
    logic                               clear_req;
    logic [NUM_BANKS*DATA_WIDTH-1:0]    data_out;
    logic [NUM_BANKS-1:0]               read_valid;
    logic                               busy;

    modport master (
        output address, data_in, WR_signal, RD_signal, clear_req,
        input  data_out, read_valid, busy
    );

    modport slave (
        input  address, data_in, WR_signal, RD_signal, clear_req,
        output data_out, read_valid, busy
    );

endinterface

// File: rtl/ram_bank.sv
// rtl/ram_bank.sv - single-port synchronous bank, write-first, registered read with valid strobe
module ram_bank #(
    parameter int DATA_WIDTH    = 64,
    parameter int ADDRESS_WIDTH = 12
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic                     re,
    input  logic [ADDRESS_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0]    din,
    output logic [DATA_WIDTH-1:0]    dout,
    output logic                     dvalid
);

    localparam int DEPTH = 2 ** ADDRESS_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // Array kept out of the reset domain so it maps onto plain RAM
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout   <= '0;
            dvalid <= 1'b0;
        end else begin
            dvalid <= re;
            if (re) begin
                dout <= we ? din : r_mem[addr];
            end
        end
    end

endmodule

// File: rtl/multi_bank_ram.sv
// rtl/multi_bank_ram.sv - NUM_BANKS independent banks plus a clear engine that zeroes all banks
module multi_bank_ram
    import ram_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int NUM_BANKS      = DEF_NUM_BANKS,
    parameter int ADDRESS_WIDTH  = DEF_ADDRESS_WIDTH,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic            clk,
    input  logic            rst,
    multi_bank_ram_if.slave bus
);

    localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;

    state_t                   r_state;
    state_t                   w_state_next;
    logic [ADDRESS_WIDTH-1:0] r_clear_cnt;
    logic [ADDRESS_WIDTH-1:0] w_clear_cnt_next;
    logic                     w_busy;

    logic [NUM_BANKS-1:0]                    w_we;
    logic [NUM_BANKS-1:0]                    w_re;
    logic [NUM_BANKS-1:0][ADDRESS_WIDTH-1:0] w_addr;
    logic [NUM_BANKS-1:0][DATA_WIDTH-1:0]    w_din;
    logic [NUM_BANKS-1:0][DATA_WIDTH-1:0]    w_dout;
    logic [NUM_BANKS-1:0]                    w_dvalid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= RESET_STATE;
            r_clear_cnt <= '0;
        end else begin
            r_state     <= w_state_next;
            r_clear_cnt <= w_clear_cnt_next;
        end
    end

    // Counter wraps to 0 on its own as the last word is written
    always_comb begin
        w_state_next     = r_state;
        w_clear_cnt_next = r_clear_cnt;
        case (r_state)
            ST_CLEAR: begin
                w_clear_cnt_next = r_clear_cnt + 1'b1;
                if (r_clear_cnt == '1) begin
                    w_state_next = ST_READY;
                end
            end
            ST_READY: begin
                if (bus.clear_req) begin
                    w_state_next     = ST_CLEAR;
                    w_clear_cnt_next = '0;
                end
            end
            default: begin
                w_state_next     = ST_READY;
                w_clear_cnt_next = '0;
            end
        endcase
    end

    assign w_busy = (r_state == ST_CLEAR);

    genvar b;
    generate
        for (b = 0; b < NUM_BANKS; b++) begin : g_bank
            // While busy the clear engine owns every bank; user commands are masked
            assign w_we[b]   = ~rst & (w_busy | bus.WR_signal[b]);
            assign w_re[b]   = ~rst & ~w_busy & bus.RD_signal[b];
            assign w_addr[b] = w_busy ? r_clear_cnt
                                      : bus.address[b*ADDRESS_WIDTH +: ADDRESS_WIDTH];
            assign w_din[b]  = w_busy ? '0 : bus.data_in[b*DATA_WIDTH +: DATA_WIDTH];

            ram_bank #(
                .DATA_WIDTH   (DATA_WIDTH),
                .ADDRESS_WIDTH(ADDRESS_WIDTH)
            ) u_bank (
                .clk   (clk),
                .rst   (rst),
                .we    (w_we[b]),
                .re    (w_re[b]),
                .addr  (w_addr[b]),
                .din   (w_din[b]),
                .dout  (w_dout[b]),
                .dvalid(w_dvalid[b])
            );
        end
    endgenerate

    assign bus.data_out   = w_dout;
    assign bus.read_valid = w_dvalid;
    assign bus.busy       = w_busy;

endmodule

// File: tb/tb_multi_bank_ram.sv
// tb/tb_multi_bank_ram.sv - scoreboard bench for multi_bank_ram with 16-word banks
module tb_multi_bank_ram;

    localparam int DW    = 64;
    localparam int NB    = 4;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    typedef struct {
        int          bank;
        logic [63:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    exp_t exp_q[$];

    multi_bank_ram_if #(.DATA_WIDTH(DW), .NUM_BANKS(NB), .ADDRESS_WIDTH(AW)) bus ();

    multi_bank_ram #(
        .DATA_WIDTH    (DW),
        .NUM_BANKS     (NB),
        .ADDRESS_WIDTH (AW),
        .CLEAR_ON_RESET(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

    function automatic logic [63:0] dout(input int b);
        return bus.data_out[b*DW +: DW];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: every asserted read_valid must match the oldest expectation for that bank
    always @(negedge clk) begin
        if (!rst) begin
            for (int b = 0; b < NB; b++) begin
                if (bus.read_valid[b] === 1'b1) begin
                    int idx;
                    idx = -1;
                    for (int k = 0; k < exp_q.size(); k++) begin
                        if (idx < 0 && exp_q[k].bank == b) idx = k;
                    end
                    n_vec++;
                    if (idx < 0) begin
                        n_err++;
                        $display("FAIL unexpected_read_valid bank%0d: data %h with no read pending", b, dout(b));
                    end else begin
                        if (dout(b) !== exp_q[idx].data) begin
                            n_err++;
                            $display("FAIL read_data bank%0d: got %h expected %h", b, dout(b), exp_q[idx].data);
                        end
                        exp_q.delete(idx);
                    end
                end
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.WR_signal = '0;
        bus.RD_signal = '0;
        bus.clear_req = 1'b0;
    endtask

    task automatic set_cmd(input int b, input logic [AW-1:0] a, input logic [63:0] d,
                           input logic wr, input logic rd);
        bus.address[b*AW +: AW] = a;
        bus.data_in[b*DW +: DW] = d;
        bus.WR_signal[b]        = wr;
        bus.RD_signal[b]        = rd;
    endtask

    task automatic expect_read(input int b, input logic [63:0] d);
        exp_t e;
        e.bank = b;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic count_busy(input string name, input int required);
        int n;
        n = 0;
        while (bus.busy === 1'b1 && n < 100) begin
            cycle();
            n++;
        end
        check(name, 64'(n), 64'(required));
    endtask

    initial begin
        bus.address = '0;
        bus.data_in = '0;
        idle_inputs();

        // 1: reset values and post-reset clear length
        #2;
        check("reset_busy", 64'(bus.busy), 64'd1);
        check("reset_read_valid", 64'(bus.read_valid), 64'd0);
        check("reset_data_out0", dout(0), 64'd0);
        cycle();
        cycle();
        rst = 1'b0;
        count_busy("clear_after_reset_cycles", DEPTH);
        for (int b = 0; b < NB; b++) begin
            set_cmd(b, 4'h7, 64'h0, 1'b0, 1'b1);
            expect_read(b, 64'h0);
        end
        cycle();
        idle_inputs();
        check("read_valid_all", 64'(bus.read_valid), 64'hf);

        // 2: write each bank, then read all back
        set_cmd(0, 4'h1, 64'h1110a716aa948111, 1'b1, 1'b0);
        set_cmd(1, 4'h2, 64'h2220a716aa9485d9, 1'b1, 1'b0);
        set_cmd(2, 4'h3, 64'h3330a716aa9485d9, 1'b1, 1'b0);
        set_cmd(3, 4'h4, 64'h4440a716aa9485d9, 1'b1, 1'b0);
        cycle();
        idle_inputs();
        for (int b = 0; b < NB; b++) bus.RD_signal[b] = 1'b1;
        expect_read(0, 64'h1110a716aa948111);
        expect_read(1, 64'h2220a716aa9485d9);
        expect_read(2, 64'h3330a716aa9485d9);
        expect_read(3, 64'h4440a716aa9485d9);
        cycle();
        idle_inputs();
        check("read_valid_after_writes", 64'(bus.read_valid), 64'hf);

        // 3: write-first on bank0, plain read on bank1
        set_cmd(0, 4'h1, 64'h5550a716aa948111, 1'b1, 1'b1);
        set_cmd(1, 4'h2, 64'h0, 1'b0, 1'b1);
        expect_read(0, 64'h5550a716aa948111);
        expect_read(1, 64'h2220a716aa9485d9);
        cycle();
        idle_inputs();

        // 4: idle cycle drops read_valid and holds data
        cycle();
        check("idle_read_valid", 64'(bus.read_valid), 64'd0);
        check("idle_hold_data0", dout(0), 64'h5550a716aa948111);
        check("idle_hold_data1", dout(1), 64'h2220a716aa9485d9);

        // 5: clear request with a same-edge write, reads masked while busy
        set_cmd(2, 4'h3, 64'h7770a716aa9485d9, 1'b1, 1'b0);
        bus.clear_req = 1'b1;
        cycle();
        idle_inputs();
        check("busy_after_clear_req", 64'(bus.busy), 64'd1);
        for (int b = 0; b < NB; b++) set_cmd(b, 4'h1, 64'h0, 1'b0, 1'b1);
        bus.clear_req = 1'b1;
        cycle();
        check("busy_read_valid", 64'(bus.read_valid), 64'd0);
        check("busy_hold_data0", dout(0), 64'h5550a716aa948111);
        idle_inputs();
        count_busy("clear_req_remaining_cycles", DEPTH - 1);
        set_cmd(2, 4'h3, 64'h0, 1'b0, 1'b1);
        set_cmd(0, 4'h1, 64'h0, 1'b0, 1'b1);
        expect_read(2, 64'h0);
        expect_read(0, 64'h0);
        cycle();
        idle_inputs();

        // 6: reset mid-clear restarts a full-length clear
        set_cmd(3, 4'h9, 64'hdeadbeef01234567, 1'b1, 1'b1);
        expect_read(3, 64'hdeadbeef01234567);
        cycle();
        idle_inputs();
        bus.clear_req = 1'b1;
        cycle();
        idle_inputs();
        for (int i = 0; i < 5; i++) cycle();
        rst = 1'b1;
        #1;
        check("midclear_reset_data3", dout(3), 64'h0);
        check("midclear_reset_valid", 64'(bus.read_valid), 64'd0);
        check("midclear_reset_busy", 64'(bus.busy), 64'd1);
        cycle();
        rst = 1'b0;
        count_busy("clear_after_midclear_reset", DEPTH);
        set_cmd(3, 4'h9, 64'h0, 1'b0, 1'b1);
        expect_read(3, 64'h0);
        cycle();
        idle_inputs();
        cycle();
        cycle();

        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
